// File: rtl/codec_i2c_pkg.sv
// Shared types and constants for the WM8731-style I2C control-port responder.
package codec_i2c_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

    // WM8731 register map (7-bit register addresses)
    localparam logic [6:0] REG_LHP    = 7'h02;
    localparam logic [6:0] REG_RHP    = 7'h03;
    localparam logic [6:0] REG_APATH  = 7'h04;
    localparam logic [6:0] REG_DPATH  = 7'h05;
    localparam logic [6:0] REG_PWR    = 7'h06;
    localparam logic [6:0] REG_DIF    = 7'h07;
    localparam logic [6:0] REG_SAMP   = 7'h08;
    localparam logic [6:0] REG_ACTIVE = 7'h09;
    localparam logic [6:0] REG_RESET  = 7'h0F;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAckA,
        StByte1,
        StAck1,
        StByte2,
        StAck2,
        StExtra,
        StIgnore
    } state_e;

    // Byte-receive state that follows each ACK slot
    function automatic state_e ack_next(input state_e s);
        case (s)
            StAckA:  return StByte1;
            StAck1:  return StByte2;
            default: return StExtra;
        endcase
    endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA synchroniser with edge, START and STOP detection.
module i2c_bus_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i2c_clk,
    input  logic i2c_dat,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_d_q;
    logic                   sda_d_q;
    logic                   scl_s;

    // Synchronise both lines; reset to 1 so an idle bus is seen after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_clk};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_dat};
            scl_d_q    <= scl_sync_q[SYNC_STAGES-1];
            sda_d_q    <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d_q;
    assign scl_fall  = ~scl_s & scl_d_q;
    // SDA may only move while SCL is high for START/STOP
    assign start_det = scl_s & scl_d_q & sda_d_q & ~sda_s;
    assign stop_det  = scl_s & scl_d_q & ~sda_d_q & sda_s;

endmodule

// File: rtl/codec_i2c_responder.sv
// Write-only I2C responder mirroring the WM8731 control port.
module codec_i2c_responder
    import codec_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_clk,
    input  logic       i2c_dat,
    output logic       i2c_dat_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic       cfg_active,
    output logic       frame_err
);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_bus_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_cond (
        .clk      (clk),
        .reset    (reset),
        .i2c_clk  (i2c_clk),
        .i2c_dat  (i2c_dat),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic [6:0] addr_tmp_q;
    logic       d8_tmp_q;
    logic       oe_q;
    logic       rx_state;
    logic       byte_done;
    logic [7:0] byte_val;

    assign rx_state  = state_q inside {StAddr, StByte1, StByte2, StExtra};
    assign byte_done = rx_state & scl_rise & (bit_cnt_q == 3'd7);
    assign byte_val  = {shift_q, sda_s};
    // Gate with reset so SDA is released in the reset cycle itself
    assign i2c_dat_oe = oe_q & reset;

    // Frame FSM: START/STOP first, then per-state bit and ACK handling
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            addr_tmp_q <= 7'd0;
            d8_tmp_q   <= 1'b0;
            oe_q       <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= 7'd0;
            wr_data    <= 9'd0;
            busy       <= 1'b0;
            cfg_active <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (start_det) begin
                state_q    <= StAddr;
                bit_cnt_q  <= 3'd0;
                shift_q    <= 7'd0;
                addr_tmp_q <= 7'd0;
                d8_tmp_q   <= 1'b0;
                oe_q       <= 1'b0;
                busy       <= 1'b1;
            end else if (stop_det) begin
                // Only a frame stopped before its write completed is an error
                if (state_q inside {StAddr, StAckA, StByte1, StAck1, StByte2}) begin
                    frame_err <= 1'b1;
                end
                state_q   <= StIdle;
                bit_cnt_q <= 3'd0;
                oe_q      <= 1'b0;
                busy      <= 1'b0;
            end else begin
                if (rx_state && scl_rise) begin
                    shift_q   <= byte_val[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                case (state_q)
                    StAddr: begin
                        if (byte_done) begin
                            if (byte_val == {DEV_ADDR, 1'b0}) begin
                                state_q <= StAckA;
                            end else begin
                                state_q   <= StIgnore;
                                frame_err <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end
                    end
                    StAckA, StAck1, StAck2: begin
                        // First fall (end of bit 8) drives ACK, second (end of bit 9) releases
                        if (scl_fall) begin
                            if (!oe_q) begin
                                oe_q <= 1'b1;
                            end else begin
                                oe_q    <= 1'b0;
                                state_q <= ack_next(state_q);
                            end
                        end
                    end
                    StByte1: begin
                        if (byte_done) begin
                            addr_tmp_q <= byte_val[7:1];
                            d8_tmp_q   <= byte_val[0];
                            state_q    <= StAck1;
                        end
                    end
                    StByte2: begin
                        if (byte_done) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= addr_tmp_q;
                            wr_data  <= {d8_tmp_q, byte_val};
                            if (addr_tmp_q == REG_ACTIVE) begin
                                cfg_active <= byte_val[0];
                            end else if (addr_tmp_q == REG_RESET) begin
                                cfg_active <= 1'b0;
                            end
                            state_q <= StAck2;
                        end
                    end
                    StExtra: begin
                        if (byte_done) begin
                            state_q   <= StIgnore;
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
